// File: rtl/ltl_nfa_engine.sv
// Runtime-programmable homogeneous NFA engine: class table, adjacency matrix and
// start/report masks are loaded through a config port; one symbol per run cycle.
module ltl_nfa_engine #(
  parameter int unsigned N_STE    = 16,
  parameter int unsigned SYMBOL_W = 8,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned STE_AW  = (N_STE > 1) ? $clog2(N_STE) : 1,
  localparam int unsigned ADDR_W  = (SYMBOL_W > STE_AW) ? SYMBOL_W : STE_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [SYMBOL_W-1:0]  symbols,
  input  logic                 flush,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [2*N_STE-1:0]   cfg_wdata,
  output logic                 cfg_err,
  output logic [N_STE-1:0]     active,
  output logic [N_STE-1:0]     report,
  output logic                 report_any,
  output logic                 report_sticky,
  output logic [CNT_W-1:0]     first_pos,
  output logic                 first_pos_valid
);

  localparam int unsigned ClassRows = 2 ** SYMBOL_W;

  logic [N_STE-1:0] class_mem [ClassRows];
  logic [N_STE-1:0] adj       [N_STE];
  logic [N_STE-1:0] sod_mask, all_mask, report_mask;

  logic [N_STE-1:0] active_q, active_d, enable;
  logic             sod_q;
  logic [CNT_W-1:0] pos_q, first_pos_q;
  logic             sticky_q, fpv_q, cfg_err_q;

  // Configuration acceptance
  logic [ADDR_W:0]  addr_ext;
  logic             addr_bad, cfg_ok;

  always_comb begin
    addr_ext = {1'b0, cfg_addr};
    addr_bad = 1'b0;
    if (cfg_sel == 2'd0) addr_bad = (addr_ext >= (ADDR_W + 1)'(ClassRows));
    if (cfg_sel == 2'd1) addr_bad = (addr_ext >= (ADDR_W + 1)'(N_STE));
    cfg_ok = cfg_we & ~run & ~flush & ~addr_bad;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < ClassRows; s++) class_mem[s] <= '0;
      for (int i = 0; i < N_STE; i++) adj[i] <= '0;
      sod_mask    <= '0;
      all_mask    <= '0;
      report_mask <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we & ~cfg_ok;
      if (cfg_ok) begin
        case (cfg_sel)
          2'd0: class_mem[cfg_addr[SYMBOL_W-1:0]] <= cfg_wdata[N_STE-1:0];
          2'd1: adj[cfg_addr[STE_AW-1:0]]         <= cfg_wdata[N_STE-1:0];
          2'd2: sod_mask                          <= cfg_wdata[N_STE-1:0];
          default: begin
            all_mask    <= cfg_wdata[N_STE-1:0];
            report_mask <= cfg_wdata[2*N_STE-1:N_STE];
          end
        endcase
      end
    end
  end

  // Next-state: an STE fires when its class matches and any enabling source is live
  always_comb begin
    enable = '0;
    for (int i = 0; i < N_STE; i++) begin
      enable[i] = (|(active_q & adj[i])) | (sod_q & sod_mask[i]) | all_mask[i];
    end
    active_d = class_mem[symbols] & enable;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q    <= '0;
      sod_q       <= 1'b1;
      pos_q       <= '0;
      first_pos_q <= '0;
      sticky_q    <= 1'b0;
      fpv_q       <= 1'b0;
    end else if (flush) begin
      active_q <= '0;
      sod_q    <= 1'b1;
      pos_q    <= '0;
      sticky_q <= 1'b0;
      fpv_q    <= 1'b0;
    end else if (run) begin
      active_q <= active_d;
      sod_q    <= 1'b0;
      if (pos_q != {CNT_W{1'b1}}) pos_q <= pos_q + CNT_W'(1);
      if (|(active_d & report_mask)) begin
        sticky_q <= 1'b1;
        if (!fpv_q) begin
          first_pos_q <= pos_q;
          fpv_q       <= 1'b1;
        end
      end
    end
  end

  assign active          = active_q;
  assign report          = active_q & report_mask;
  assign report_any      = |report;
  assign report_sticky   = sticky_q;
  assign first_pos       = first_pos_q;
  assign first_pos_valid = fpv_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// Scoreboard bench for ltl_nfa_engine: a set-based reference model predicts every
// post-edge output; a monitor pops and compares one prediction per clock.
module tb_ltl_nfa_engine;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0, flush = 1'b0, cfg_we = 1'b0;
  logic [7:0]  symbols = '0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_err, report_any, report_sticky, first_pos_valid;
  logic [15:0] active, report;
  logic [31:0] first_pos;

  ltl_nfa_engine #(.N_STE(16), .SYMBOL_W(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols), .flush(flush),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .active(active), .report(report), .report_any(report_any),
    .report_sticky(report_sticky), .first_pos(first_pos), .first_pos_valid(first_pos_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] act;
    logic [15:0] rep;
    logic        any;
    logic        st;
    logic        fpv;
    logic        err;
    logic [31:0] fp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  bit [15:0] m_class [256];
  bit [15:0] m_adj [16];
  bit [15:0] m_sod, m_all, m_rep, m_act;
  bit        m_sodf, m_st, m_fpv, m_err;
  bit [31:0] m_pos, m_fp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 256; s++) m_class[s] = '0;
    for (int i = 0; i < N; i++) m_adj[i] = '0;
    m_sod = '0; m_all = '0; m_rep = '0; m_act = '0;
    m_sodf = 1'b1; m_st = 1'b0; m_fpv = 1'b0; m_err = 1'b0;
    m_pos = '0; m_fp = '0;
  endfunction

  // One clock edge of the reference: successors of every live state, plus start sources
  function automatic void model_edge(input bit r, input bit [7:0] s, input bit f, input bit we,
                                     input bit [1:0] sel, input bit [7:0] addr,
                                     input bit [31:0] wd);
    bit [15:0] nxt;
    bit        live;
    if (f) begin
      m_act = '0; m_pos = '0; m_st = 1'b0; m_fpv = 1'b0; m_sodf = 1'b1;
    end else if (r) begin
      nxt = '0;
      for (int i = 0; i < N; i++) begin
        live = m_all[i] || (m_sodf && m_sod[i]);
        for (int j = 0; j < N; j++) if (m_act[j] && m_adj[i][j]) live = 1'b1;
        if (live && m_class[s][i]) nxt[i] = 1'b1;
      end
      m_act = nxt;
      m_sodf = 1'b0;
      if ((nxt & m_rep) != 0) begin
        m_st = 1'b1;
        if (!m_fpv) begin m_fp = m_pos; m_fpv = 1'b1; end
      end
      if (m_pos != 32'hFFFF_FFFF) m_pos++;
    end
    m_err = 1'b0;
    if (we) begin
      if (r || f) m_err = 1'b1;
      else if (sel == 2'd0) m_class[addr] = wd[15:0];
      else if (sel == 2'd1) begin
        if (addr >= N) m_err = 1'b1;
        else m_adj[addr[3:0]] = wd[15:0];
      end
      else if (sel == 2'd2) m_sod = wd[15:0];
      else begin m_all = wd[15:0]; m_rep = wd[31:16]; end
    end
  endfunction

  task automatic step(input bit r, input bit [7:0] s, input bit f, input bit we,
                      input bit [1:0] sel, input bit [7:0] addr, input bit [31:0] wd);
    exp_t e;
    @(negedge clk);
    run = r; symbols = s; flush = f; cfg_we = we; cfg_sel = sel; cfg_addr = addr;
    cfg_wdata = wd;
    model_edge(r, s, f, we, sel, addr, wd);
    e.act = m_act; e.rep = m_act & m_rep; e.any = |(m_act & m_rep);
    e.st = m_st; e.fpv = m_fpv; e.err = m_err; e.fp = m_fp;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    run = 1'b0; flush = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg(input bit [1:0] sel, input bit [7:0] addr, input bit [31:0] wd);
    step(1'b0, 8'h00, 1'b0, 1'b1, sel, addr, wd);
  endtask

  task automatic sym(input bit [7:0] s);
    step(1'b1, s, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
  endtask

  task automatic do_flush();
    step(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 32'h0);
  endtask

  task automatic idle(input bit [7:0] s);
    step(1'b0, s, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, 32'(active), 32'h0);
    chk({tag, "_report"}, 32'(report), 32'h0);
    chk({tag, "_any"}, 32'(report_any), 32'h0);
    chk({tag, "_sticky"}, 32'(report_sticky), 32'h0);
    chk({tag, "_fpos"}, first_pos, 32'h0);
    chk({tag, "_fpv"}, 32'(first_pos_valid), 32'h0);
    chk({tag, "_err"}, 32'(cfg_err), 32'h0);
  endtask

  // Monitor: one prediction per edge, sampled after outputs settle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("active", 32'(active), 32'(e.act));
      chk("report", 32'(report), 32'(e.rep));
      chk("report_any", 32'(report_any), 32'(e.any));
      chk("report_sticky", 32'(report_sticky), 32'(e.st));
      chk("first_pos_valid", 32'(first_pos_valid), 32'(e.fpv));
      chk("cfg_err", 32'(cfg_err), 32'(e.err));
      if (e.fpv) chk("first_pos", first_pos, e.fp);
    end
  end

  initial begin
    int op;
    bit [7:0] a;
    model_reset();
    #2;
    chk_all_zero("reset");
    #10 reset = 1'b1;

    // Chain "AB"
    cfg(2'd0, 8'h41, 32'h0001);
    cfg(2'd0, 8'h42, 32'h0002);
    cfg(2'd2, 8'h00, 32'h0001);
    cfg(2'd1, 8'h01, 32'h0001);
    cfg(2'd3, 8'h00, 32'h0002_0000);
    do_flush();
    sym("A");
    chk("ab_no_early_report", 32'(report), 32'h0);
    sym("B");
    chk("ab_report", 32'(report), 32'h0002);
    chk("ab_first_pos", first_pos, 32'd1);
    sym("A");
    sym("B");
    chk("ab_first_pos_kept", first_pos, 32'd1);

    // Start-of-data only, then all-input
    do_flush();
    sym("x"); sym("x"); sym("A"); sym("B");
    chk("sod_only_no_report", 32'(report_sticky), 32'h0);
    cfg(2'd3, 8'h00, 32'h0002_0001);
    do_flush();
    sym("x"); sym("x"); sym("A"); sym("B");
    chk("all_first_pos", first_pos, 32'd3);

    // Self-loop over two symbol ranges
    for (int s = 0; s < 32; s++) begin
      cfg(2'd0, 8'(s), 32'h0001);
      cfg(2'd0, 8'(s + 128), 32'h0001);
    end
    cfg(2'd1, 8'h00, 32'h0001);
    cfg(2'd1, 8'h01, 32'h0000);
    cfg(2'd3, 8'h00, 32'h0001_0000);
    do_flush();
    sym(8'h05); sym(8'h85); sym(8'h10);
    chk("loop_report", 32'(report), 32'h0001);
    sym(8'h40); sym(8'h05); sym(8'h10);
    chk("loop_dead", 32'(report), 32'h0);

    // run gating mid-match
    do_flush();
    sym(8'h05);
    idle(8'h40); idle(8'h05); idle(8'h40);
    chk("gate_active", 32'(active), 32'h0001);
    sym(8'h10);
    chk("gate_resume", 32'(active), 32'h0001);

    // Config guard: write during run, out-of-range adjacency row, write during flush
    step(1'b1, 8'h05, 1'b0, 1'b1, 2'd0, 8'h40, 32'h0001);
    chk("guard_err_pulse", 32'(cfg_err), 32'h1);
    sym(8'h40);
    chk("guard_row_kept", 32'(active), 32'h0);
    cfg(2'd1, 8'd200, 32'hFFFF);
    cfg(2'd1, 8'd16, 32'hFFFF);
    step(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h00, 32'hFFFF);

    // flush with run and a matching symbol
    do_flush();
    sym(8'h05);
    step(1'b1, 8'h05, 1'b1, 1'b0, 2'd0, 8'h00, 32'h0);
    chk("flush_sticky", 32'(report_sticky), 32'h0);
    sym(8'h05);
    chk("flush_sod_rearmed", 32'(active), 32'h0001);

    // Reset mid-report
    #1 reset = 1'b0;
    #1 chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    for (int k = 0; k < 8; k++) sym(8'(k * 3));
    chk("unprogrammed_silent", 32'(report_sticky), 32'h0);

    // Randomised phase over a small alphabet
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 99);
      if (op < 12) begin
        case ($urandom_range(0, 3))
          0: cfg(2'd0, 8'($urandom_range(0, 15)), $urandom());
          1: cfg(2'd1, 8'($urandom_range(0, 19)), $urandom() & $urandom());
          2: cfg(2'd2, 8'h00, $urandom());
          default: cfg(2'd3, 8'h00, $urandom() & 32'hFFFF_0F0F);
        endcase
      end else if (op < 16) begin
        do_flush();
      end else if (op < 24) begin
        idle(8'($urandom_range(0, 15)));
      end else if (op < 28) begin
        a = 8'($urandom_range(0, 15));
        step($urandom_range(0, 1) == 1, a, 1'b1, 1'b1, 2'd0, a, $urandom());
      end else if (op < 31) begin
        step(1'b1, 8'($urandom_range(0, 15)), 1'b0, 1'b1, 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 15)), $urandom());
      end else begin
        sym(8'($urandom_range(0, 15)));
      end
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
